// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit types: store buffer entry layout and access widths.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } store_width_t;

  typedef struct packed {
    logic [31:0]  address;
    logic [31:0]  data;
    store_width_t store_width;
  } store_buffer_entry_t;

endpackage

// File: rtl/store_drain_arbiter.sv
// Arbitrates one memory port between the store buffer drain and a load requester,
// with a starvation limit on loads and a fence that drains every buffered store.
module store_drain_arbiter
  import load_store_unit_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sb_empty_i,
  input  logic                sb_full_i,
  input  store_buffer_entry_t sb_packet_i,
  output logic                sb_pull_o,
  input  logic                ld_request_i,
  input  logic [31:0]         ld_address_i,
  output logic                ld_accept_o,
  output logic                ld_done_o,
  output logic [31:0]         ld_data_o,
  output logic                mem_request_o,
  output logic                mem_write_o,
  output logic [31:0]         mem_address_o,
  output logic [31:0]         mem_data_o,
  output store_width_t        mem_width_o,
  input  logic                mem_ready_i,
  input  logic                mem_done_i,
  input  logic [31:0]         mem_data_i,
  input  logic                fence_i,
  output logic                fence_done_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    STORE_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             r_fence_pending;
  logic             w_fence_nxt;
  logic             w_store_forced;
  logic             w_grant_load;
  logic             w_grant_store;
  logic             w_fence_done;

  // Forced stores outrank loads; otherwise loads win unless a fence is draining.
  assign w_store_forced = !sb_empty_i && (r_fence_pending || sb_full_i || (r_starve_cnt == CNT_MAX));
  assign w_grant_load   = !w_store_forced && ld_request_i && !r_fence_pending;
  assign w_grant_store  = !sb_empty_i && !w_grant_load;
  assign w_fence_done   = r_fence_pending && (r_state == IDLE) && sb_empty_i;
  assign w_fence_nxt    = fence_i || (r_fence_pending && !w_fence_done);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_starve_cnt    <= '0;
      r_fence_pending <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_starve_cnt    <= w_starve_nxt;
      r_fence_pending <= w_fence_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_starve_nxt  = r_starve_cnt;
    sb_pull_o     = 1'b0;
    ld_accept_o   = 1'b0;
    ld_done_o     = 1'b0;
    ld_data_o     = '0;
    mem_request_o = 1'b0;
    mem_write_o   = 1'b0;
    mem_address_o = '0;
    mem_data_o    = '0;
    mem_width_o   = BYTE;
    fence_done_o  = w_fence_done;

    case (r_state)
      IDLE: begin
        if (w_grant_store) begin
          mem_request_o = 1'b1;
          mem_write_o   = 1'b1;
          mem_address_o = sb_packet_i.address;
          mem_data_o    = sb_packet_i.data;
          mem_width_o   = sb_packet_i.store_width;
          if (mem_ready_i) begin
            sb_pull_o    = 1'b1;
            w_starve_nxt = '0;
            w_state_nxt  = STORE_WAIT;
          end
        end else if (w_grant_load) begin
          mem_request_o = 1'b1;
          mem_address_o = ld_address_i;
          mem_width_o   = WORD;
          if (mem_ready_i) begin
            ld_accept_o = 1'b1;
            w_state_nxt = LOAD_WAIT;
            if (!sb_empty_i && (r_starve_cnt != CNT_MAX)) begin
              w_starve_nxt = r_starve_cnt + 1'b1;
            end
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_done_i) begin
          ld_done_o   = 1'b1;
          ld_data_o   = mem_data_i;
          w_state_nxt = IDLE;
        end
      end
      STORE_WAIT: begin
        if (mem_done_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are held quiet for the whole reset assertion, not just after the edge.
    if (rst_i) begin
      sb_pull_o     = 1'b0;
      ld_accept_o   = 1'b0;
      ld_done_o     = 1'b0;
      ld_data_o     = '0;
      mem_request_o = 1'b0;
      mem_write_o   = 1'b0;
      mem_address_o = '0;
      mem_data_o    = '0;
      mem_width_o   = BYTE;
      fence_done_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_drain_arbiter.sv
// Bench for store_drain_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules and a queue-based store buffer.
module tb_store_drain_arbiter;
  import load_store_unit_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int SB_DEPTH   = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                sb_empty_i;
  logic                sb_full_i;
  store_buffer_entry_t sb_packet_i;
  logic                sb_pull_o;
  logic                ld_request_i;
  logic [31:0]         ld_address_i;
  logic                ld_accept_o;
  logic                ld_done_o;
  logic [31:0]         ld_data_o;
  logic                mem_request_o;
  logic                mem_write_o;
  logic [31:0]         mem_address_o;
  logic [31:0]         mem_data_o;
  store_width_t        mem_width_o;
  logic                mem_ready_i;
  logic                mem_done_i;
  logic [31:0]         mem_data_i;
  logic                fence_i;
  logic                fence_done_o;

  store_drain_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sb_empty_i   (sb_empty_i),
    .sb_full_i    (sb_full_i),
    .sb_packet_i  (sb_packet_i),
    .sb_pull_o    (sb_pull_o),
    .ld_request_i (ld_request_i),
    .ld_address_i (ld_address_i),
    .ld_accept_o  (ld_accept_o),
    .ld_done_o    (ld_done_o),
    .ld_data_o    (ld_data_o),
    .mem_request_o(mem_request_o),
    .mem_write_o  (mem_write_o),
    .mem_address_o(mem_address_o),
    .mem_data_o   (mem_data_o),
    .mem_width_o  (mem_width_o),
    .mem_ready_i  (mem_ready_i),
    .mem_done_i   (mem_done_i),
    .mem_data_i   (mem_data_i),
    .fence_i      (fence_i),
    .fence_done_o (fence_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: is a transfer outstanding, was it a load, load streak, fence.
  bit m_busy;
  bit m_load;
  int m_cnt;
  bit m_fence;
  store_buffer_entry_t sbq[$];
  int seq[$];   // observed events: 0 load accept, 1 store pull, 2 fence done

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_load  = 1'b0;
    m_cnt   = 0;
    m_fence = 1'b0;
  endtask

  task automatic push_entry();
    store_buffer_entry_t e;
    e.address     = $urandom;
    e.data        = $urandom;
    e.store_width = store_width_t'($urandom_range(0, 2));
    sbq.push_back(e);
  endtask

  // 0 = nobody, 1 = store buffer, 2 = load requester
  function automatic int pick_source();
    bit empty = (sbq.size() == 0);
    bit full  = (sbq.size() >= SB_DEPTH);
    if (m_busy) return 0;
    if (!empty && (m_fence || full || m_cnt == STARVE_MAX)) return 1;
    if (ld_request_i && !m_fence) return 2;
    if (!empty) return 1;
    return 0;
  endfunction

  // One clock: inputs already set at the falling edge; check settled outputs, then advance.
  task automatic step();
    int src;
    logic e_req, e_wr, e_pull, e_acc, e_done, e_fd;
    logic [31:0] e_addr, e_data, e_ldd;
    logic [1:0] e_w;
    sb_empty_i  = (sbq.size() == 0);
    sb_full_i   = (sbq.size() >= SB_DEPTH);
    sb_packet_i = (sbq.size() == 0) ? '0 : sbq[0];
    #1;
    if (rst_i) model_reset();
    src    = rst_i ? 0 : pick_source();
    e_req  = (src != 0);
    e_wr   = (src == 1);
    e_pull = (src == 1) && mem_ready_i;
    e_acc  = (src == 2) && mem_ready_i;
    e_addr = (src == 1) ? sb_packet_i.address : (src == 2) ? ld_address_i : 32'h0;
    e_data = (src == 1) ? sb_packet_i.data : 32'h0;
    e_w    = (src == 1) ? sb_packet_i.store_width : (src == 2) ? 2'(WORD) : 2'(BYTE);
    e_done = !rst_i && m_busy && m_load && mem_done_i;
    e_ldd  = e_done ? mem_data_i : 32'h0;
    e_fd   = !rst_i && m_fence && !m_busy && (sbq.size() == 0);
    chk("mem_request", 32'(mem_request_o), 32'(e_req));
    chk("mem_write",   32'(mem_write_o),   32'(e_wr));
    chk("sb_pull",     32'(sb_pull_o),     32'(e_pull));
    chk("ld_accept",   32'(ld_accept_o),   32'(e_acc));
    chk("ld_done",     32'(ld_done_o),     32'(e_done));
    chk("ld_data",     ld_data_o,          e_ldd);
    chk("fence_done",  32'(fence_done_o),  32'(e_fd));
    if (e_req || rst_i) begin
      chk("mem_address", mem_address_o, e_addr);
      chk("mem_width",   32'(mem_width_o), 32'(e_w));
    end
    if (e_wr || rst_i) chk("mem_data", mem_data_o, e_data);
    if (fence_done_o) seq.push_back(2);
    if (sb_pull_o)    seq.push_back(1);
    if (ld_accept_o)  seq.push_back(0);
    if (!rst_i) begin
      if (e_pull) begin
        m_busy = 1'b1; m_load = 1'b0; m_cnt = 0;
        void'(sbq.pop_front());
      end else if (e_acc) begin
        m_busy = 1'b1; m_load = 1'b1;
        if (sbq.size() != 0 && m_cnt < STARVE_MAX) m_cnt++;
      end else if (m_busy && mem_done_i) begin
        m_busy = 1'b0;
      end
      m_fence = fence_i || (m_fence && !e_fd);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  int exp_starve[6] = '{0, 0, 0, 0, 1, 0};
  int exp_fence[5]  = '{1, 1, 1, 2, 0};
  int n_fd;
  int pulls_before;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; ld_request_i = 1'b1; ld_address_i = 32'h1000; mem_ready_i = 1'b1;
    mem_done_i = 1'b1; mem_data_i = 32'hdead_beef; fence_i = 1'b0;
    sb_empty_i = 1'b1; sb_full_i = 1'b0; sb_packet_i = '0;
    model_reset();
    push_entry();
    @(negedge clk_i);
    step();
    step();

    // Quiet release: nothing may be requested straight out of reset.
    sbq.delete(); ld_request_i = 1'b0; mem_done_i = 1'b0; rst_i = 1'b0;
    step();

    // Single store drain.
    push_entry(); seq.delete();
    step();
    mem_ready_i = 1'b0; mem_done_i = 1'b1;
    step();
    chk("single_store_pulls", 32'(seq.size()), 32'd1);

    // Starvation limit: four loads, one store, loads resume.
    push_entry(); push_entry(); seq.delete();
    ld_request_i = 1'b1; mem_ready_i = 1'b1; mem_done_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ld_address_i = $urandom; mem_data_i = $urandom;
      step();
    end
    chk("starve_len", 32'(seq.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      if (i < seq.size()) chk("starve_seq", 32'(seq[i]), 32'(exp_starve[i]));

    // Full buffer beats a pending load.
    while (sbq.size() < SB_DEPTH) push_entry();
    seq.delete();
    step();
    step();
    chk("full_first_is_store", 32'((seq.size() > 0) ? seq[0] : 9), 32'd1);
    ld_request_i = 1'b0;
    for (int i = 0; i < 20 && (sbq.size() != 0 || m_busy); i++) step();
    chk("drain_done", 32'(sbq.size()), 32'd0);

    // Fence with three stores queued and a load waiting.
    push_entry(); push_entry(); push_entry(); seq.delete();
    ld_request_i = 1'b1; mem_ready_i = 1'b0; fence_i = 1'b1;
    step();
    fence_i = 1'b0; mem_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("fence_len", 32'(seq.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < seq.size()) chk("fence_seq", 32'(seq[i]), 32'(exp_fence[i]));
    n_fd = 0;
    foreach (seq[i]) if (seq[i] == 2) n_fd++;
    chk("fence_done_count", 32'(n_fd), 32'd1);

    // Fence on an empty buffer completes one cycle later.
    ld_request_i = 1'b0;
    for (int i = 0; i < 20 && (sbq.size() != 0 || m_busy); i++) step();
    fence_i = 1'b1;
    step();
    fence_i = 1'b0;
    chk("empty_fence_next_cycle_pre", 32'(fence_done_o), 32'd1);
    step();

    // Memory stalls: request held, nothing pulled for five cycles.
    push_entry(); mem_ready_i = 1'b0; mem_done_i = 1'b0;
    pulls_before = seq.size();
    for (int i = 0; i < 5; i++) step();
    chk("stall_no_pull", 32'(seq.size() - pulls_before), 32'd0);
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;

    // Reset while a store is outstanding.
    rst_i = 1'b1; mem_done_i = 1'b1;
    step();
    rst_i = 1'b0; mem_done_i = 1'b0;
    step();

    // Mid-cycle reset pulse abandons a load with no clock edge in between.
    ld_request_i = 1'b1; ld_address_i = 32'h4444_0000; mem_ready_i = 1'b1;
    step();
    ld_request_i = 1'b0; mem_done_i = 1'b1; mem_data_i = 32'h1234_5678; rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    model_reset();
    step();

    // Random traffic.
    mem_done_i = 1'b0;
    for (int i = 0; i < 600; i++) begin
      ld_request_i = 1'($urandom_range(0, 1));
      ld_address_i = $urandom;
      mem_ready_i  = ($urandom_range(0, 3) != 0);
      mem_done_i   = 1'($urandom_range(0, 1));
      mem_data_i   = $urandom;
      fence_i      = ($urandom_range(0, 19) == 0);
      if (sbq.size() < SB_DEPTH && $urandom_range(0, 2) == 0) push_entry();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_drain_arbiter.md
STORE_DRAIN_ARBITER -- requirements
Module: store_drain_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive load grants while the store buffer is non-empty.
REQ-002 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port sb_empty_i, input, 1: store buffer empty.
REQ-005 SHALL have port sb_full_i, input, 1: store buffer full (push-side status).
REQ-006 SHALL have port sb_packet_i, input, store_buffer_entry_t: head entry, valid whenever sb_empty_i=0 (first-word-fall-through).
REQ-007 SHALL have port sb_pull_o, output, 1: pop head entry.
REQ-008 SHALL have ports ld_request_i (in, 1), ld_address_i (in, 32), ld_accept_o (out, 1), ld_done_o (out, 1), ld_data_o (out, 32): load requester.
REQ-009 SHALL have ports mem_request_o (out, 1), mem_write_o (out, 1), mem_address_o (out, 32), mem_data_o (out, 32), mem_width_o (out, store_width_t), mem_ready_i (in, 1), mem_done_i (in, 1), mem_data_i (in, 32): single memory port.
REQ-010 SHALL have ports fence_i (in, 1) and fence_done_o (out, 1): drain-all request and completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD_WAIT, STORE_WAIT.
REQ-012 In IDLE, grant priority: (1) store if sb_empty_i=0 and (fence pending, or sb_full_i=1, or starve_cnt=STARVE_MAX); (2) load if ld_request_i=1; (3) store if sb_empty_i=0.
REQ-013 A grant SHALL drive mem_request_o=1 combinationally in IDLE, with address/data/width/write from the granted source; the transfer is accepted only in the cycle mem_ready_i=1.
REQ-014 On store acceptance: sb_pull_o=1 for exactly that cycle, starve_cnt cleared, next state STORE_WAIT.
REQ-015 On load acceptance: ld_accept_o=1 for that cycle, mem_width_o=WORD, mem_write_o=0, next state LOAD_WAIT; starve_cnt increments (saturating at STARVE_MAX) only if sb_empty_i=0.
REQ-016 If mem_ready_i=0, the FSM SHALL remain in IDLE and re-arbitrate the next cycle; no pull or accept is issued.
REQ-017 In LOAD_WAIT/STORE_WAIT, mem_request_o=0; on mem_done_i=1 return to IDLE; in LOAD_WAIT also ld_done_o=1 and ld_data_o=mem_data_i that cycle.
REQ-018 mem_done_i in IDLE SHALL be ignored.
REQ-019 fence_i=1 for one cycle SHALL set fence_pending; loads are blocked while fence_pending=1.
REQ-020 fence_done_o SHALL pulse one cycle when fence_pending=1, FSM in IDLE and sb_empty_i=1; fence_pending clears same cycle. Fence with empty buffer in IDLE completes the next cycle.
REQ-021 Arbitration latency IDLE->memory request: 0 cycles; minimum store/load occupancy: 2 cycles (accept + done).

Reset
REQ-022 rst_i SHALL force, asynchronously: state=IDLE, starve_cnt=0, fence_pending=0.
REQ-023 During and directly after reset all outputs SHALL be 0 (sb_pull_o, ld_accept_o, ld_done_o, ld_data_o, mem_* , fence_done_o); an in-flight transfer is abandoned without pull/done.

Structure
REQ-024 store_buffer_entry_t (address 32, data 32, store_width) and store_width_t (BYTE, HALF, WORD) SHALL live in load_store_unit_pkg; the FSM state enum SHALL be local.
REQ-025 Single module; no sub-module.

Verification
REQ-026 sb_empty_i=0, ld_request_i=0, mem_ready_i=1, mem_done_i one cycle later -> sb_pull_o 1 cycle, mem_write_o=1, address/data equal head entry.
REQ-027 Continuous ld_request_i with non-empty buffer, STARVE_MAX=4 -> exactly 4 loads granted, then one store, then loads resume.
REQ-028 sb_full_i=1 with ld_request_i=1 -> store granted first.
REQ-029 fence_i pulse with 3 entries and ld_request_i=1 -> 3 stores drained, no load accepted, fence_done_o pulses once, then load accepted.
REQ-030 mem_ready_i=0 for 5 cycles -> mem_request_o held, no sb_pull_o/ld_accept_o; rst_i in STORE_WAIT -> IDLE, all outputs 0 immediately.
